// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO and a runtime bit period.
// The bit period is sampled when a byte is popped and held for the whole frame.
module uart_transmitter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [15:0]                  clks_per_bit_i,
  input  logic                         tx_valid_i,
  input  logic [7:0]                   tx_byte_i,
  output logic                         tx_ready_o,
  output logic                         tx_serial_o,
  output logic                         tx_active_o,
  output logic                         tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic           fifo_empty, push, pop;

  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [15:0] cpb_q, cpb_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit_end;
  logic        serial_d, active_d, done_d;

  // Extra pointer bit distinguishes full from empty.
  assign fifo_level_o = wr_ptr_q - rd_ptr_q;
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign tx_ready_o   = (fifo_level_o != LvlW'(FIFO_DEPTH));
  assign push         = tx_valid_i && tx_ready_o;
  assign pop          = (state_q == StIdle) && !fifo_empty;
  assign bit_end      = (clk_cnt_q == cpb_q - 16'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LvlW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LvlW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[AddrW-1:0]] <= tx_byte_i;
  end

  // State register, including the registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      cpb_q       <= 16'd1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_o <= 1'b1;
      tx_active_o <= 1'b0;
      tx_done_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      cpb_q       <= cpb_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_o <= serial_d;
      tx_active_o <= active_d;
      tx_done_o   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    cpb_d     = cpb_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          shift_d   = fifo_mem[rd_ptr_q[AddrW-1:0]];
          cpb_d     = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from next state so the line moves on the same edge as the FSM.
  always_comb begin
    serial_d = 1'b1;
    active_d = (state_d != StIdle);
    done_d   = (state_q == StStop) && (state_d == StIdle);
    case (state_d)
      StStart: serial_d = 1'b0;
      StData:  serial_d = shift_d[bit_idx_d];
      default: serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table of single frames, a frame-decoding
// monitor fed by a scoreboard queue, and hand sequences for FIFO, CPB change and reset.
module tb_uart_transmitter;

  logic        clk, rst;
  logic [15:0] clks_per_bit;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready, tx_serial, tx_active, tx_done;
  logic [2:0]  fifo_level;

  uart_transmitter #(.FIFO_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clks_per_bit_i(clks_per_bit),
    .tx_valid_i    (tx_valid),
    .tx_byte_i     (tx_byte),
    .tx_ready_o    (tx_ready),
    .tx_serial_o   (tx_serial),
    .tx_active_o   (tx_active),
    .tx_done_o     (tx_done),
    .fifo_level_o  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  frame;  // bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
    int unsigned cpb;
  } sb_t;

  typedef struct {
    logic [15:0] cpb;
    logic [7:0]  data;
    int unsigned eff;
    logic [9:0]  frame;
  } vec_t;

  sb_t sb[$];
  time start_times[$];
  time accept_time;
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  bit  mon_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [9:0] f, input int unsigned eff);
    bit ok = 0;
    sb_t e;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = d;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("push_accept", {31'd0, tx_ready}, 1);
      tx_valid = 1'b0;
    end else begin
      e.frame = f;
      e.cpb   = eff;
      sb.push_back(e);
      @(posedge clk);
      accept_time = $time;
      #1 tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_busy && !tx_active) begin
        ok = 1;
        break;
      end
    end
    check("idle_reached", {31'd0, ok}, 1);
  endtask

  // Frame monitor: every active frame must match the scoreboard head, bit for bit and cycle
  // for cycle, and be followed by a done pulse in an idle cycle.
  initial begin
    sb_t         e;
    int          errs;
    bit          aborted;
    logic [3:0]  bit_no;
    forever begin
      @(negedge clk);
      if (!rst && tx_active) begin
        mon_busy = 1;
        start_times.push_back($time);
        check("frame_expected", {31'd0, sb.size() > 0}, 1);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
          e.frame = 10'h3ff;
          e.cpb   = 1;
        end
        errs    = 0;
        aborted = 0;
        for (int unsigned c = 0; c < 10 * e.cpb; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          bit_no = 4'(c / e.cpb);
          if (tx_serial !== e.frame[bit_no] || tx_active !== 1'b1) errs++;
        end
        if (!aborted) begin
          check("frame_bits", errs, 0);
          @(negedge clk);
          if (!rst) begin
            check("frame_done", {31'd0, tx_done}, 1);
            check("frame_end_idle", {31'd0, tx_active}, 0);
          end
        end
        mon_busy = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && tx_done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   d0, n0, errs;
    time  t0;

    vecs[0] = '{cpb: 16'd4,  data: 8'hA5, eff: 4,  frame: 10'b1101001010};
    vecs[1] = '{cpb: 16'd0,  data: 8'hFF, eff: 1,  frame: 10'b1111111110};
    vecs[2] = '{cpb: 16'd1,  data: 8'h00, eff: 1,  frame: 10'b1000000000};
    vecs[3] = '{cpb: 16'd3,  data: 8'h5A, eff: 3,  frame: 10'b1010110100};
    vecs[4] = '{cpb: 16'd16, data: 8'h55, eff: 16, frame: 10'b1010101010};
    vecs[5] = '{cpb: 16'd16, data: 8'hAA, eff: 16, frame: 10'b1101010100};
    vecs[6] = '{cpb: 16'd5,  data: 8'h81, eff: 5,  frame: 10'b1100000010};
    vecs[7] = '{cpb: 16'd2,  data: 8'h7E, eff: 2,  frame: 10'b1011111100};

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_byte = 8'h00;
    clks_per_bit = 16'd4;
    #23;
    check("rst_serial", {31'd0, tx_serial}, 1);
    check("rst_active", {31'd0, tx_active}, 0);
    check("rst_done",   {31'd0, tx_done}, 0);
    check("rst_ready",  {31'd0, tx_ready}, 1);
    check("rst_level",  {29'd0, fifo_level}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single frames: shape, 1-cycle start latency, one done pulse each.
    for (int i = 0; i < 8; i++) begin
      clks_per_bit = vecs[i].cpb;
      start_times.delete();
      d0 = done_cnt;
      push(vecs[i].data, vecs[i].frame, vecs[i].eff);
      wait_idle(400);
      check("start_latency", (start_times.size() > 0) ? 32'(start_times[0] - accept_time) : 0, 15);
      check("done_count", done_cnt - d0, 1);
    end

    // FIFO fill, full flag, stall and pointer wrap.
    clks_per_bit = 16'd2;
    start_times.delete();
    d0 = done_cnt;
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), {1'b1, 8'(i), 1'b0}, 2);
    end
    @(negedge clk);
    check("fifo_full_level", {29'd0, fifo_level}, 4);
    check("fifo_full_ready", {31'd0, tx_ready}, 0);
    push(8'h06, {1'b1, 8'h06, 1'b0}, 2);
    wait_idle(400);
    check("fifo_done_count", done_cnt - d0, 6);
    check("fifo_frames", start_times.size(), 6);
    errs = 0;
    for (int i = 1; i < start_times.size(); i++) begin
      if (start_times[i] - start_times[i-1] != 210) errs++;
    end
    check("fifo_frame_gap", errs, 0);

    // Bit period change mid-frame applies only to the next frame.
    clks_per_bit = 16'd8;
    start_times.delete();
    push(8'h3C, 10'b1001111000, 8);
    repeat (30) @(negedge clk);
    clks_per_bit = 16'd3;
    push(8'hC3, 10'b1110000110, 3);
    wait_idle(400);
    check("cpb_change_gap", (start_times.size() == 2) ? 32'(start_times[1] - start_times[0]) : 0,
          810);

    // Reset during DATA with two bytes queued.
    clks_per_bit = 16'd4;
    push(8'h11, 10'b1000100010, 4);
    push(8'h22, 10'b1000100100, 4);
    push(8'h33, 10'b1001100110, 4);
    repeat (12) @(negedge clk);
    check("pre_rst_level", {29'd0, fifo_level}, 2);
    check("pre_rst_active", {31'd0, tx_active}, 1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_serial", {31'd0, tx_serial}, 1);
    check("rst_mid_active", {31'd0, tx_active}, 0);
    check("rst_mid_level",  {29'd0, fifo_level}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = start_times.size();
    t0 = $time;
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_active !== 1'b0) errs++;
    end
    check("post_rst_quiet", errs, 0);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_no_frame", start_times.size() - n0, 0);
    check("post_rst_ready", {31'd0, tx_ready}, 1);
    if (t0 == 0) errs++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
